// File: rtl/limn2600_mem_arbiter.sv
// Two-port bus arbiter in front of a word-only SRAM: fetch port 0, load/store port 1.
// Sub-word stores become read-modify-write; an SRAM that never answers ends the access with err.
module limn2600_mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [3:0]  p1_be,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic            r_port, w_port;
  logic            r_we, w_we;
  logic            r_rmw, w_rmw;
  logic            r_last, w_last;
  logic [3:0]      r_be, w_be;
  logic [31:0]     r_wdata, w_wdata;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_mem_cs, w_mem_cs;
  logic            r_mem_we, w_mem_we;
  logic [31:0]     r_mem_addr, w_mem_addr;
  logic [31:0]     r_mem_wdata, w_mem_wdata;
  logic            r_p0_ack, w_p0_ack;
  logic            r_p1_ack, w_p1_ack;
  logic            r_err, w_err;
  logic [31:0]     r_p0_rdata, w_p0_rdata;
  logic [31:0]     r_p1_rdata, w_p1_rdata;
  logic            w_grant1;
  logic            w_grant_any;
  logic            w_unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

  // r_last = 1 means port 1 was served last, so a tie goes to port 0.
  assign w_grant1      = p1_req & (~p0_req | ~RR_EN | ~r_last);
  assign w_grant_any   = p0_req | p1_req;
  assign w_unused_addr = ^{p0_addr[1:0], p1_addr[1:0]};

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    w_state     = r_state;
    w_port      = r_port;
    w_we        = r_we;
    w_rmw       = r_rmw;
    w_last      = r_last;
    w_be        = r_be;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_mem_cs    = 1'b0;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_p0_ack    = 1'b0;
    w_p1_ack    = 1'b0;
    w_err       = 1'b0;
    w_p0_rdata  = r_p0_rdata;
    w_p1_rdata  = r_p1_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_port     = w_grant1;
          w_last     = w_grant1;
          w_we       = w_grant1 & p1_we;
          w_be       = p1_be;
          w_wdata    = p1_wdata;
          w_mem_addr = {(w_grant1 ? p1_addr[31:2] : p0_addr[31:2]), 2'b00};
          if (w_grant1 && p1_we && (p1_be == 4'h0)) begin
            w_state  = S_DONE;
            w_p1_ack = 1'b1;
          end else begin
            w_state     = S_ISSUE;
            w_mem_cs    = 1'b1;
            w_mem_we    = w_grant1 & p1_we & (p1_be == 4'hF);
            w_mem_wdata = p1_wdata;
            w_rmw       = w_grant1 & p1_we & (p1_be != 4'hF);
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state = S_WAIT;
        w_cnt   = {CW{1'b0}};
      end
      S_WAIT: begin
        if (mem_rdy) begin
          if (r_rmw) begin
            // Read phase of a sub-word store: merge and go back out as a write.
            w_state     = S_ISSUE;
            w_mem_cs    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_wdata = merge_bytes(mem_rdata, r_wdata, r_be);
            w_rmw       = 1'b0;
          end else if (r_port) begin
            w_state    = S_DONE;
            w_p1_ack   = 1'b1;
            w_p1_rdata = r_we ? r_p1_rdata : mem_rdata;
          end else begin
            w_state    = S_DONE;
            w_p0_ack   = 1'b1;
            w_p0_rdata = mem_rdata;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state = S_DONE;
          w_err   = 1'b1;
          w_rmw   = 1'b0;
          if (r_port) begin
            w_p1_ack   = 1'b1;
            w_p1_rdata = 32'h0000_0000;
          end else begin
            w_p0_ack   = 1'b1;
            w_p0_rdata = 32'h0000_0000;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_rmw       <= 1'b0;
      r_last      <= 1'b1;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0000_0000;
      r_cnt       <= {CW{1'b0}};
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_err       <= 1'b0;
      r_p0_rdata  <= 32'h0000_0000;
      r_p1_rdata  <= 32'h0000_0000;
    end else begin
      r_state     <= w_state;
      r_port      <= w_port;
      r_we        <= w_we;
      r_rmw       <= w_rmw;
      r_last      <= w_last;
      r_be        <= w_be;
      r_wdata     <= w_wdata;
      r_cnt       <= w_cnt;
      r_mem_cs    <= w_mem_cs;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_p0_ack    <= w_p0_ack;
      r_p1_ack    <= w_p1_ack;
      r_err       <= w_err;
      r_p0_rdata  <= w_p0_rdata;
      r_p1_rdata  <= w_p1_rdata;
    end
  end

  assign p0_ack    = r_p0_ack;
  assign p0_rdata  = r_p0_rdata;
  assign p1_ack    = r_p1_ack;
  assign p1_rdata  = r_p1_rdata;
  assign err       = r_err;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
